// File: rtl/fpu_norm_pkg.sv
// Shared types and helpers for the extended-precision normalizer arbiter.
package fpu_norm_pkg;

    localparam int unsigned FP80_W           = 80;
    localparam int unsigned EXP_W            = 15;
    localparam int unsigned MANT_W           = 64;
    localparam int unsigned NORM_LATENCY_DEF = 5;

    // Slot fields are sized for the widest supported configuration (8 requesters, 16-bit tags).
    localparam int unsigned SLOT_ID_W  = 3;
    localparam int unsigned SLOT_TAG_W = 16;

    typedef struct packed {
        logic                  valid;
        logic [SLOT_ID_W-1:0]  id;
        logic [SLOT_TAG_W-1:0] tag;
        logic                  zero;
        logic                  sign;
    } norm_slot_t;

    function automatic logic fp_sign(input logic [FP80_W-1:0] op);
        return op[FP80_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [FP80_W-1:0] op);
        return op[FP80_W-2 -: EXP_W];
    endfunction

    function automatic logic [MANT_W-1:0] fp_mant(input logic [FP80_W-1:0] op);
        return op[MANT_W-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or after the pointer wins, pointer moves past the winner.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic           advance,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id
);

    logic [IDW-1:0] ptr;
    logic           found;
    int unsigned    idx;

    // Upward search from the pointer with wrap-around.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    // Pointer advances one past the accepted requester; holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_id == IDW'(N-1)) ? '0 : grant_id + IDW'(1);
        end
    end

endmodule

// File: rtl/fpu_normalizer_arbiter.sv
// Shares one fixed-latency normalizer between FPU requesters; a tag delay line routes results home.
module fpu_normalizer_arbiter
    import fpu_norm_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned TAG_W        = 4,
    parameter int unsigned NORM_LATENCY = NORM_LATENCY_DEF,
    localparam int unsigned ID_W  = $clog2(NUM_REQ),
    localparam int unsigned INF_W = $clog2(NORM_LATENCY + 2)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*FP80_W-1:0] req_operand,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic                      flush,
    output logic [FP80_W-1:0]         norm_in,
    input  logic [FP80_W-1:0]         norm_out,
    output logic                      res_valid,
    output logic [ID_W-1:0]           res_req_id,
    output logic [TAG_W-1:0]          res_tag,
    output logic [FP80_W-1:0]         res_data,
    output logic                      res_zero,
    output logic                      busy,
    output logic [INF_W-1:0]          inflight
);

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               accept;
    logic [TAG_W-1:0]   sel_tag;
    norm_slot_t         slot_in;
    norm_slot_t         line [NORM_LATENCY];
    norm_slot_t         tail;
    logic [INF_W-1:0]   inflight_nxt;

    // No grants while a flush is being taken.
    assign arb_req   = flush ? '0 : req_valid;
    assign req_ready = grant;
    assign accept    = |grant;
    assign tail      = line[NORM_LATENCY-1];

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (arb_req),
        .advance  (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Operand mux and stage-0 slot; an empty issue slot carries zeros.
    always_comb begin
        norm_in = '0;
        sel_tag = '0;
        slot_in = '0;
        if (accept) begin
            norm_in       = req_operand[FP80_W*int'(grant_id) +: FP80_W];
            sel_tag       = req_tag[TAG_W*int'(grant_id) +: TAG_W];
            slot_in.valid = 1'b1;
            slot_in.id    = SLOT_ID_W'(grant_id);
            slot_in.tag   = SLOT_TAG_W'(sel_tag);
            slot_in.zero  = (fp_mant(norm_in) == '0);
            slot_in.sign  = fp_sign(norm_in);
        end
    end

    // Delay line shifting in lockstep with the normalizer; flush kills every valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NORM_LATENCY; i++) begin
                line[i] <= '0;
            end
        end else begin
            line[0] <= slot_in;
            for (int unsigned i = 1; i < NORM_LATENCY; i++) begin
                line[i] <= line[i-1];
            end
            if (flush) begin
                for (int unsigned i = 0; i < NORM_LATENCY; i++) begin
                    line[i].valid <= 1'b0;
                end
            end
        end
    end

    // Result register: zero-mantissa operands bypass the normalizer as signed zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid  <= 1'b0;
            res_req_id <= '0;
            res_tag    <= '0;
            res_data   <= '0;
            res_zero   <= 1'b0;
        end else begin
            res_valid <= tail.valid & ~flush;
            if (tail.valid) begin
                res_req_id <= ID_W'(tail.id);
                res_tag    <= TAG_W'(tail.tag);
                res_zero   <= tail.zero;
                res_data   <= tail.zero ? {tail.sign, {(FP80_W-1){1'b0}}} : norm_out;
            end
        end
    end

    // Occupancy covers the delay line plus the result register, so it retires when res_valid drops out.
    always_comb begin
        inflight_nxt = inflight;
        if (flush) begin
            inflight_nxt = '0;
        end else if (accept && !res_valid) begin
            inflight_nxt = inflight + INF_W'(1);
        end else if (!accept && res_valid) begin
            inflight_nxt = inflight - INF_W'(1);
        end
    end

    // Occupancy and busy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
            busy     <= 1'b0;
        end else begin
            inflight <= inflight_nxt;
            busy     <= (inflight_nxt != '0);
        end
    end

endmodule

// File: tb/tb_fpu_normalizer_arbiter.sv
// Directed bench for fpu_normalizer_arbiter with an ideal fixed-latency normalizer stub.
module tb_fpu_normalizer_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned LAT     = 5;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned INF_W   = 3;

    localparam logic [79:0] OP_A  = 80'h4000_8000_0000_0000_0001;
    localparam logic [79:0] OP_Z  = 80'hC005_0000_0000_0000_0000;
    localparam logic [79:0] RES_Z = 80'h8000_0000_0000_0000_0000;
    localparam logic [79:0] OP_F  = 80'h3FFF_C000_0000_0000_0000;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*80-1:0]    req_operand;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic                     flush;
    logic [79:0]              norm_in;
    logic [79:0]              norm_out;
    logic                     res_valid;
    logic [ID_W-1:0]          res_req_id;
    logic [TAG_W-1:0]         res_tag;
    logic [79:0]              res_data;
    logic                     res_zero;
    logic                     busy;
    logic [INF_W-1:0]         inflight;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [79:0] norm_pipe [LAT];

    fpu_normalizer_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .TAG_W        (TAG_W),
        .NORM_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_operand (req_operand),
        .req_tag     (req_tag),
        .flush       (flush),
        .norm_in     (norm_in),
        .norm_out    (norm_out),
        .res_valid   (res_valid),
        .res_req_id  (res_req_id),
        .res_tag     (res_tag),
        .res_data    (res_data),
        .res_zero    (res_zero),
        .busy        (busy),
        .inflight    (inflight)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ideal normalizer: identity function, LAT edges deep.
    always @(posedge clk) begin
        norm_pipe[0] <= norm_in;
        for (int i = 1; i < LAT; i++) norm_pipe[i] <= norm_pipe[i-1];
    end
    assign norm_out = norm_pipe[LAT-1];

    function automatic logic [79:0] op_of(input int i);
        return {16'h3FF0 + 16'(i), 64'hC000_0000_0000_0000 | 64'(i + 1)};
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input int i);
        return TAG_W'(i + 5);
    endfunction

    task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Advance to just after the rising edge that starts cycle n.
    task automatic goto(input int n);
        if (cyc > n) begin
            $display("FAIL goto: cycle %0d already past %0d", cyc, n);
            $fatal(1);
        end
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        req_valid   = '0;
        req_operand = '0;
        req_tag     = '0;

        // Reset state
        goto(3);
        reset = 1'b0;
        smp();
        check_eq("rst_valid",    80'(res_valid),  80'(0));
        check_eq("rst_inflight", 80'(inflight),   80'(0));
        check_eq("rst_busy",     80'(busy),       80'(0));
        check_eq("rst_data",     res_data,        80'(0));
        check_eq("rst_id",       80'(res_req_id), 80'(0));
        check_eq("rst_tag",      80'(res_tag),    80'(0));
        check_eq("rst_zero",     80'(res_zero),   80'(0));
        check_eq("rst_ready",    80'(req_ready),  80'(0));

        // Single request from requester 0 in cycle 10, result in cycle 16
        goto(10);
        req_valid         = 4'b0001;
        req_operand[79:0] = OP_A;
        req_tag[3:0]      = 4'h3;
        smp();
        check_eq("a_ready",  80'(req_ready), 80'(4'b0001));
        check_eq("a_normin", norm_in,        OP_A);
        for (int c = 11; c <= 17; c++) begin
            goto(c);
            req_valid = '0;
            smp();
            check_eq("a_res_valid", 80'(res_valid), 80'(c == 16));
            check_eq("a_inflight",  80'(inflight),  80'((c <= 16) ? 1 : 0));
            check_eq("a_busy",      80'(busy),      80'(c <= 16));
            if (c == 16) begin
                check_eq("a_id",   80'(res_req_id), 80'(0));
                check_eq("a_tag",  80'(res_tag),    80'(4'h3));
                check_eq("a_data", res_data,        OP_A);
                check_eq("a_zero", 80'(res_zero),   80'(0));
            end
        end

        // Zero-mantissa operand from requester 2 (pointer sits at 1)
        goto(20);
        req_valid            = 4'b0100;
        req_operand[239:160] = OP_Z;
        req_tag[11:8]        = 4'h9;
        smp();
        check_eq("z_ready", 80'(req_ready), 80'(4'b0100));
        goto(21);
        req_valid = '0;
        goto(25);
        smp();
        check_eq("z_early", 80'(res_valid), 80'(0));
        goto(26);
        smp();
        check_eq("z_valid", 80'(res_valid),  80'(1));
        check_eq("z_zero",  80'(res_zero),   80'(1));
        check_eq("z_data",  res_data,        RES_Z);
        check_eq("z_id",    80'(res_req_id), 80'(2));
        check_eq("z_tag",   80'(res_tag),    80'(4'h9));

        // Flush after accepts in cycles 30..32
        req_operand[159:80] = OP_F;
        req_tag[7:4]        = 4'h6;
        for (int c = 30; c <= 40; c++) begin
            goto(c);
            req_valid = (c <= 33) ? 4'b0010 : 4'b0000;
            flush     = (c == 33);
            smp();
            if (c <= 32) check_eq("f_ready", 80'(req_ready), 80'(4'b0010));
            if (c == 33) begin
                check_eq("f_ready_flush", 80'(req_ready), 80'(0));
                check_eq("f_inflight_pre", 80'(inflight), 80'(3));
            end
            if (c >= 34) check_eq("f_res_valid", 80'(res_valid), 80'(0));
            if (c == 34) begin
                check_eq("f_inflight", 80'(inflight), 80'(0));
                check_eq("f_busy",     80'(busy),     80'(0));
            end
        end

        // Reset with three in flight
        req_operand[319:240] = OP_A;
        for (int c = 50; c <= 59; c++) begin
            goto(c);
            req_valid = (c <= 52) ? 4'b1000 : 4'b0000;
            reset     = (c == 53);
            smp();
            if (c == 50) check_eq("r_ready", 80'(req_ready), 80'(4'b1000));
            if (c >= 54) check_eq("r_res_valid", 80'(res_valid), 80'(0));
            if (c == 54) begin
                check_eq("r_inflight", 80'(inflight), 80'(0));
                check_eq("r_busy",     80'(busy),     80'(0));
            end
        end

        // Contention: all four valid for cycles 60..67
        for (int i = 0; i < 4; i++) begin
            req_operand[80*i +: 80]       = op_of(i);
            req_tag[TAG_W*i +: TAG_W]     = tag_of(i);
        end
        for (int c = 60; c <= 74; c++) begin
            goto(c);
            req_valid = (c <= 67) ? 4'b1111 : 4'b0000;
            smp();
            if (c <= 67) check_eq("c_ready", 80'(req_ready), 80'(4'b0001 << ((c - 60) % 4)));
            if (c >= 61) begin
                if (c <= 66)      check_eq("c_inflight", 80'(inflight), 80'(c - 60));
                else if (c <= 68) check_eq("c_inflight", 80'(inflight), 80'(6));
                else              check_eq("c_inflight", 80'(inflight), 80'(74 - c));
                if (c >= 66 && c <= 73) begin
                    check_eq("c_res_valid", 80'(res_valid),  80'(1));
                    check_eq("c_id",        80'(res_req_id), 80'((c - 66) % 4));
                    check_eq("c_tag",       80'(res_tag),    80'(tag_of((c - 66) % 4)));
                    check_eq("c_data",      res_data,        op_of((c - 66) % 4));
                    check_eq("c_zero",      80'(res_zero),   80'(0));
                end else begin
                    check_eq("c_res_valid", 80'(res_valid), 80'(0));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_normalizer_arbiter.md
Name: fpu_normalizer_arbiter

Overview:
- Shares one fixed-latency, non-stallable 80-bit extended-precision normalizer pipeline between NUM_REQ FPU requesters (e.g. adder, multiplier, divider, int-to-float).
- Arbitration is round-robin with one issue per cycle.
- A valid/id/tag delay line runs in lockstep with the normalizer so each result is routed back to its requester.
- Zero-mantissa operands are detected and the result forced to signed zero, because the normalizer cannot handle them.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TAG_W, 4, opaque per-request tag width, returned with the result.
- NORM_LATENCY, 5, clock edges from norm_in capture to corresponding norm_out.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; handshake = valid&ready in the same cycle.
- req_operand  in  NUM_REQ*80  packed operands; requester i in bits [80*i+79:80*i].
- req_tag  in  NUM_REQ*TAG_W  packed tags.
- flush  in  1  squash all in-flight work (FPU exception / pipeline abort).
- norm_in  out  80  operand to normalizer.
- norm_out  in  80  normalizer result.
- res_valid  out  1  result strobe, one cycle; no backpressure.
- res_req_id  out  clog2(NUM_REQ)  requester owning the result.
- res_tag  out  TAG_W  tag of the request.
- res_data  out  80  normalized result.
- res_zero  out  1  result is a forced signed zero.
- busy  out  1  any slot in flight or res_valid high.
- inflight  out  clog2(NORM_LATENCY+2)  accepted but not yet returned count.

Behaviour:
- Reset: pointer=0, all delay-line valids=0, res_valid=0, res_req_id/res_tag/res_data/res_zero=0, inflight=0, busy=0.
- Arbitration (combinational):
  - Grant the first asserted req_valid at or after the pointer, searching upward with wrap.
  - req_ready is one-hot or zero. A requester must not make req_valid depend on req_ready.
- After an accept from requester i: pointer <= (i+1) mod NUM_REQ. With no accept, the pointer holds.
- norm_in = granted operand; all-zero when there is no grant (the slot is issued invalid).
- Delay line: NORM_LATENCY stages of {valid, id, tag, zero, sign}.
  - Stage 0 is captured at the same edge the normalizer captures norm_in.
  - The tail aligns with norm_out.
  - zero = (operand[63:0]==0); sign = operand[79].
- Result register, loaded each cycle from the tail:
  - res_valid = tail.valid & ~flush.
  - res_data = tail.zero ? {tail.sign, 79'b0} : norm_out.
  - res_zero = tail.zero.
  - res_req_id and res_tag come from the tail.
  - When the tail is invalid, res_data holds its previous value and res_valid=0.
- Latency: an accept in cycle T gives res_valid high in cycle T+NORM_LATENCY+1 (default 6). Throughput is 1 per cycle.
- inflight: +1 on accept, -1 when a valid tail is loaded into the result register; both in one cycle leaves it unchanged. Maximum value is NORM_LATENCY+1.
- busy = (inflight != 0).
- flush:
  - In the flush cycle req_ready=0 and the pointer holds.
  - All delay-line valids clear at the edge, and the tail exiting that cycle is dropped (res_valid=0 next cycle).
  - inflight <= 0; a result already showing in res_valid completes normally.
- Reset mid-operation: everything clears as on reset. In-flight results are lost and no res_valid is produced for them.
- The normalizer carries no valid signal and is never stalled; all correctness derives from delay-line alignment.

Decomposition:
- Package fpu_norm_pkg:
  - FP80_W=80, EXP_W=15, MANT_W=64, NORM_LATENCY default.
  - Delay-line slot struct {valid, id, tag, zero, sign}.
  - Field-extract helper functions for sign, exponent and mantissa.
- One sub-module: rr_arbiter (NUM_REQ-wide round-robin, req vector plus advance strobe in, one-hot grant out, pointer state inside).
- The normalizer is instantiated by the parent, not inside this block.

Test Plan:
- Bench stub: norm_out = norm_in delayed NORM_LATENCY edges.
- Single request: req0 operand 80'h4000_8000000000000001, tag 4'h3, accepted cycle 10 -> res_valid only in cycle 16 with id=0, tag=3, data equal to the operand; inflight 1 during cycles 11..16.
- Contention: all 4 requesters valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; results 6 cycles later in the same order with matching tags; no cycle without res_valid.
- Zero operand: req2 operand 80'hC005_0000000000000000 -> res_zero=1, res_data=80'h8000_0000000000000000, id=2.
- Flush: accepts in cycles 20,21,22, flush in cycle 23 -> no res_valid in cycles 24..30, inflight=0 in cycle 24, and req_ready=0 in cycle 23 despite req_valid.
- Reset mid-run: reset in cycle 13 with 3 in flight -> no res_valid afterward; pointer=0, so with all requesters valid the first grant after reset goes to requester 0.
- Sparse plus same-cycle retire: one accept per cycle while results exit -> inflight holds at 6 (NORM_LATENCY+1) and never overflows.
